pipe_execute_stage: RTL and testbench
=====================================

// Module: pipe_execute_stage
// PURPOSE
//  Y86-64 execute stage for the pipelined core. Takes the E-register fields and computes valE,
//  the branch/cmov condition and the condition codes. Results are registered into the M-stage
//  pipeline register. Width is parametrised, stall/bubble control is provided, the CC register
//  is gated, and a combinational forwarding path feeds decode.
// PARAMETERS
//  DATA_W   64    datapath width (bits); power of 2, >= 16
//  REG_W    4     register-id width
//  RNONE    4'hF  "no register" id
//  EXT_OPS  0     1: OPq also accepts ifun 4=shl and 5=sar
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  e_valid    in   1       E-stage holds a real instruction (0 = bubble)
//  e_stat     in   3       status: AOK=1 HLT=2 ADR=3 INS=4
//  e_icode    in   4       instruction code
//  e_ifun     in   4       function code
//  e_valA/B/C in   DATA_W  operands from decode/fetch
//  e_dstE/M   in   REG_W   destination ids
//  set_cc_en  in   1       0 when M/W hold an exception; blocks CC update
//  m_stall    in   1       hold the M register
//  m_bubble   in   1       load a nop into the M register
//  fwd_valE   out  DATA_W  combinational valE, for forwarding
//  fwd_dstE   out  REG_W   combinational effective dstE, for forwarding
//  m_valid, m_stat, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM   out  registered M fields
//  cc_zf, cc_sf, cc_of   out  1  condition-code register
// BEHAVIOUR
//  Reset (async, immediate): m_valid=0, m_stat=AOK, m_icode=4'h1 (nop), m_cnd=0, m_valE=0,
//   m_valA=0, m_dstE=m_dstM=RNONE, cc_zf=1, cc_sf=0, cc_of=0.
//  Latency: 1 cycle from E inputs to M outputs; fwd_* are same-cycle combinational.
//  valE by icode:
//   2 cmov: valA. 3 irmov: valC. 4/5 rm/mrmov: valB+valC.
//   8 call, A push: valB-8. 9 ret, B pop: valB+8. Other icodes: 0.
//  OPq (icode 6):
//   ifun 0 A+B; 1 valB-valA; 2 A&B; 3 A^B.
//   EXT_OPS=1 only: ifun 4 valB<<valA[log2(DATA_W)-1:0]; ifun 5 arithmetic >> by the same amount.
//   Any other ifun: valE=0 and m_stat=INS (if e_stat=AOK).
//   All arithmetic is modulo 2^DATA_W; carry is discarded.
//  Flags: ZF = (valE==0); SF = valE[DATA_W-1].
//   OF for add: sign(A)==sign(B) && sign(valE)!=sign(A).
//   OF for sub: sign(B)!=sign(A) && sign(valE)!=sign(B).
//   OF = 0 for logic and shift ops.
//  CC write at the clock edge iff e_valid & icode==6 & valid ifun & set_cc_en & e_stat==AOK
//   & !m_stall. Otherwise CC holds.
//  Condition (ifun, evaluated on the CURRENT CC register): 0 always; 1 le (SF^OF)|ZF;
//   2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7-F -> 0.
//  m_cnd = condition for icode 2/7; 0 for all other icodes.
//  fwd_dstE = RNONE when icode==2 and the condition is false; otherwise e_dstE.
//   m_dstE takes the same value.
//  Priority at each edge: rst > m_stall (M holds, CC holds) > m_bubble (M loads reset values,
//   CC may still update from the E instruction) > normal load.
//  e_valid=0 is treated as a bubble: M loads a nop and there is no CC write.
//  Reset mid-operation drops the in-flight instruction; there is no replay.
// TESTING
//  1 OPq sub, valA=5 valB=3 -> next edge m_valE=64'hFFFF_FFFF_FFFF_FFFE, SF=1 ZF=0 OF=0;
//    then cmovl dstE=3 -> m_cnd=1, m_dstE=3.
//  2 OPq add, A=64'h7FFF_FFFF_FFFF_FFFF B=1 -> valE=64'h8000_0000_0000_0000, SF=1 OF=1;
//    then jl -> m_cnd=0; jg -> m_cnd=1.
//  3 OPq xor, A=B=7 with set_cc_en=0 -> m_valE=0, CC unchanged; the following cmove uses the old ZF.
//  4 m_stall=1 with m_bubble=1 -> M and CC hold; m_bubble alone -> m_icode=1, m_valid=0, m_dstE=RNONE.
//  5 EXT_OPS=1 shl, A=4 B=1 -> m_valE=16; EXT_OPS=0 same ifun -> m_stat=INS, m_valE=0, CC unchanged.
//  6 pushq valB=0x100 -> m_valE=0xF8; assert rst mid-cycle -> outputs reach reset values before next edge.

Source files
------------

// File: rtl/pipe_execute_stage.sv
// Y86-64 execute stage: computes valE, the cmov/jump condition and the
// condition codes, then registers the result into the M-stage pipeline
// register. A combinational copy of valE/dstE is exported for forwarding.
module pipe_execute_stage #(
    parameter int               DATA_W  = 64,
    parameter int               REG_W   = 4,
    parameter logic [REG_W-1:0] RNONE   = '1,
    parameter bit               EXT_OPS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e_valid,
    input  logic [2:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_ifun,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [DATA_W-1:0] e_valB,
    input  logic [DATA_W-1:0] e_valC,
    input  logic [REG_W-1:0]  e_dstE,
    input  logic [REG_W-1:0]  e_dstM,
    input  logic              set_cc_en,
    input  logic              m_stall,
    input  logic              m_bubble,
    output logic [DATA_W-1:0] fwd_valE,
    output logic [REG_W-1:0]  fwd_dstE,
    output logic              m_valid,
    output logic [2:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic              m_cnd,
    output logic [DATA_W-1:0] m_valE,
    output logic [DATA_W-1:0] m_valA,
    output logic [REG_W-1:0]  m_dstE,
    output logic [REG_W-1:0]  m_dstM,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic signed [DATA_W-1:0] STACK_STEP = DATA_W'(8);

    // Signed overflow of r = a + b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Signed overflow of r = b - a: operands differ in sign, result leaves b's sign.
    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (b[DATA_W-1] != a[DATA_W-1]) && (r[DATA_W-1] != b[DATA_W-1]);
    endfunction

    // Branch / cmov condition from the condition-code register.
    function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                       input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return lt | zf;
            4'h2:    return lt;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return !lt;
            4'h6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    logic signed [DATA_W-1:0] val_a_p0, val_b_p0, val_c_p0, val_e_p0;
    logic [SH_W-1:0]          sh_amt_p0;
    logic                     op_ok_p0, of_p0, opq_bad_p0, cc_we_p0, cnd_p0;
    logic [REG_W-1:0]         dst_e_p0;
    logic [2:0]               stat_p0;

    assign val_a_p0  = e_valA;
    assign val_b_p0  = e_valB;
    assign val_c_p0  = e_valC;
    assign sh_amt_p0 = e_valA[SH_W-1:0];

    // ---- E stage: ALU and overflow flag ----
    // Select valE by instruction; op_ok drops for OPq function codes not supported.
    always_comb begin
        val_e_p0 = '0;
        op_ok_p0 = 1'b1;
        of_p0    = 1'b0;
        case (e_icode)
            I_CMOV:          val_e_p0 = val_a_p0;
            I_IRMOV:         val_e_p0 = val_c_p0;
            I_RMMOV, I_MRMOV: val_e_p0 = val_b_p0 + val_c_p0;
            I_CALL, I_PUSH:  val_e_p0 = val_b_p0 - STACK_STEP;
            I_RET, I_POP:    val_e_p0 = val_b_p0 + STACK_STEP;
            I_OPQ: begin
                case (e_ifun)
                    4'h0: begin
                        val_e_p0 = val_a_p0 + val_b_p0;
                        of_p0    = add_ovf(val_a_p0, val_b_p0, val_e_p0);
                    end
                    4'h1: begin
                        val_e_p0 = val_b_p0 - val_a_p0;
                        of_p0    = sub_ovf(val_a_p0, val_b_p0, val_e_p0);
                    end
                    4'h2: val_e_p0 = val_a_p0 & val_b_p0;
                    4'h3: val_e_p0 = val_a_p0 ^ val_b_p0;
                    4'h4: begin
                        if (EXT_OPS) val_e_p0 = val_b_p0 <<< sh_amt_p0;
                        else         op_ok_p0 = 1'b0;
                    end
                    4'h5: begin
                        if (EXT_OPS) val_e_p0 = val_b_p0 >>> sh_amt_p0;
                        else         op_ok_p0 = 1'b0;
                    end
                    default: op_ok_p0 = 1'b0;
                endcase
            end
            default: val_e_p0 = '0;
        endcase
    end

    assign opq_bad_p0 = (e_icode == I_OPQ) && !op_ok_p0;
    assign cc_we_p0   = e_valid && (e_icode == I_OPQ) && op_ok_p0 && set_cc_en &&
                        (e_stat == S_AOK) && !m_stall;
    assign cnd_p0     = ((e_icode == I_CMOV) || (e_icode == I_JXX)) ?
                        cond_eval(e_ifun, cc_zf, cc_sf, cc_of) : 1'b0;
    assign dst_e_p0   = ((e_icode == I_CMOV) && !cnd_p0) ? RNONE : e_dstE;
    assign stat_p0    = (opq_bad_p0 && (e_stat == S_AOK)) ? S_INS : e_stat;

    assign fwd_valE = val_e_p0;
    assign fwd_dstE = dst_e_p0;

    // ---- E -> M pipeline register ----
    // Stall holds M; a bubble or an empty E slot loads a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_stat  <= S_AOK;
            m_icode <= I_NOP;
            m_cnd   <= 1'b0;
            m_valE  <= '0;
            m_valA  <= '0;
            m_dstE  <= RNONE;
            m_dstM  <= RNONE;
        end else if (m_stall) begin
            m_valid <= m_valid;
        end else if (m_bubble || !e_valid) begin
            m_valid <= 1'b0;
            m_stat  <= S_AOK;
            m_icode <= I_NOP;
            m_cnd   <= 1'b0;
            m_valE  <= '0;
            m_valA  <= '0;
            m_dstE  <= RNONE;
            m_dstM  <= RNONE;
        end else begin
            m_valid <= 1'b1;
            m_stat  <= stat_p0;
            m_icode <= e_icode;
            m_cnd   <= cnd_p0;
            m_valE  <= val_e_p0;
            m_valA  <= e_valA;
            m_dstE  <= dst_e_p0;
            m_dstM  <= e_dstM;
        end
    end

    // Condition codes update only from a clean, committed OPq (bubble does not block it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (cc_we_p0) begin
            cc_zf <= (val_e_p0 == '0);
            cc_sf <= val_e_p0[DATA_W-1];
            cc_of <= of_p0;
        end
    end

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Bench for pipe_execute_stage: two instances (EXT_OPS=0 and 1) share stimulus
// and are compared against an instruction-level reference model.
module tb_pipe_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_valid;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_ifun;
    logic [63:0] e_valA, e_valB, e_valC;
    logic [3:0]  e_dstE, e_dstM;
    logic        set_cc_en, m_stall, m_bubble;

    logic [63:0] fwd_valE [2];
    logic [3:0]  fwd_dstE [2];
    logic        m_valid  [2];
    logic [2:0]  m_stat   [2];
    logic [3:0]  m_icode  [2];
    logic        m_cnd    [2];
    logic [63:0] m_valE   [2];
    logic [63:0] m_valA   [2];
    logic [3:0]  m_dstE   [2];
    logic [3:0]  m_dstM   [2];
    logic        cc_zf    [2];
    logic        cc_sf    [2];
    logic        cc_of    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_execute_stage #(
            .DATA_W (64),
            .REG_W  (4),
            .RNONE  (4'hF),
            .EXT_OPS(g == 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .e_valid  (e_valid),
            .e_stat   (e_stat),
            .e_icode  (e_icode),
            .e_ifun   (e_ifun),
            .e_valA   (e_valA),
            .e_valB   (e_valB),
            .e_valC   (e_valC),
            .e_dstE   (e_dstE),
            .e_dstM   (e_dstM),
            .set_cc_en(set_cc_en),
            .m_stall  (m_stall),
            .m_bubble (m_bubble),
            .fwd_valE (fwd_valE[g]),
            .fwd_dstE (fwd_dstE[g]),
            .m_valid  (m_valid[g]),
            .m_stat   (m_stat[g]),
            .m_icode  (m_icode[g]),
            .m_cnd    (m_cnd[g]),
            .m_valE   (m_valE[g]),
            .m_valA   (m_valA[g]),
            .m_dstE   (m_dstE[g]),
            .m_dstM   (m_dstM[g]),
            .cc_zf    (cc_zf[g]),
            .cc_sf    (cc_sf[g]),
            .cc_of    (cc_of[g])
        );
    end

    // M fields: valid, stat, icode, cnd, valE, valA, dstE, dstM
    localparam logic [144:0] RST_M = {1'b0, 3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
    localparam logic [2:0]   RST_CC = 3'b100;

    logic [144:0] exp_m  [2];
    logic [2:0]   cc_m   [2];
    int errors = 0;
    int checks = 0;

    function automatic logic [147:0] obs(input int d);
        return {m_valid[d], m_stat[d], m_icode[d], m_cnd[d], m_valE[d], m_valA[d],
                m_dstE[d], m_dstM[d], cc_zf[d], cc_sf[d], cc_of[d]};
    endfunction

    task automatic chk(input string tag, input logic [147:0] got, input logic [147:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: what M and CC should hold after the next edge.
    task automatic model(input int d, output logic [144:0] nm, output logic [2:0] ncc,
                         output logic [63:0] fv, output logic [3:0] fd);
        logic              zf, sf, of, lt, taken, legal, nof, cnd;
        logic signed [64:0] wide;
        logic [63:0]       v;
        logic [2:0]        st;
        {zf, sf, of} = cc_m[d];
        lt = (sf != of);
        case (e_ifun)
            4'h0: taken = 1'b1;
            4'h1: taken = lt || zf;
            4'h2: taken = lt;
            4'h3: taken = zf;
            4'h4: taken = !zf;
            4'h5: taken = !lt;
            4'h6: taken = !lt && !zf;
            default: taken = 1'b0;
        endcase
        legal = 1'b1;
        nof   = 1'b0;
        v     = 64'd0;
        wide  = '0;
        case (e_icode)
            4'h2: v = e_valA;
            4'h3: v = e_valC;
            4'h4, 4'h5: v = e_valB + e_valC;
            4'h8, 4'hA: v = e_valB - 64'd8;
            4'h9, 4'hB: v = e_valB + 64'd8;
            4'h6: begin
                case (e_ifun)
                    4'h0: begin
                        wide = $signed({e_valA[63], e_valA}) + $signed({e_valB[63], e_valB});
                        v = wide[63:0];
                        nof = (wide[64] != wide[63]);
                    end
                    4'h1: begin
                        wide = $signed({e_valB[63], e_valB}) - $signed({e_valA[63], e_valA});
                        v = wide[63:0];
                        nof = (wide[64] != wide[63]);
                    end
                    4'h2: v = e_valA & e_valB;
                    4'h3: v = e_valA ^ e_valB;
                    4'h4: if (d == 1) v = e_valB << e_valA[5:0]; else legal = 1'b0;
                    4'h5: if (d == 1) v = $signed(e_valB) >>> e_valA[5:0]; else legal = 1'b0;
                    default: legal = 1'b0;
                endcase
            end
            default: v = 64'd0;
        endcase
        cnd = (e_icode == 4'h2 || e_icode == 4'h7) ? taken : 1'b0;
        fd  = (e_icode == 4'h2 && !taken) ? 4'hF : e_dstE;
        fv  = v;
        st  = (e_icode == 4'h6 && !legal && e_stat == 3'd1) ? 3'd4 : e_stat;
        if (m_stall)                 nm = exp_m[d];
        else if (m_bubble || !e_valid) nm = RST_M;
        else                         nm = {1'b1, st, e_icode, cnd, v, e_valA, fd, e_dstM};
        if (e_valid && e_icode == 4'h6 && legal && set_cc_en && e_stat == 3'd1 && !m_stall)
            ncc = {v == 64'd0, v[63], nof};
        else
            ncc = cc_m[d];
    endtask

    task automatic set_e(input logic v, input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [3:0] de, input logic [3:0] dm);
        e_valid = v; e_stat = st; e_icode = ic; e_ifun = fn;
        e_valA = a; e_valB = b; e_valC = c; e_dstE = de; e_dstM = dm;
        set_cc_en = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    endtask

    // Check forwarding mid-cycle, clock once, then check M and CC of both instances.
    task automatic cycle();
        logic [144:0] nm [2];
        logic [2:0]   ncc [2];
        logic [63:0]  fv;
        logic [3:0]   fd;
        #1;
        for (int d = 0; d < 2; d++) begin
            model(d, nm[d], ncc[d], fv, fd);
            chk($sformatf("fwd%0d", d), {76'd0, fwd_valE[d], fwd_dstE[d]}, {76'd0, fv, fd});
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_m[d] = nm[d];
            cc_m[d]  = ncc[d];
            chk($sformatf("mreg%0d", d), obs(d), {exp_m[d], cc_m[d]});
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        set_e(1'b0, 3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        for (int d = 0; d < 2; d++) begin
            exp_m[d] = RST_M;
            cc_m[d]  = RST_CC;
        end
        #1;
        chk("reset0", obs(0), {RST_M, RST_CC});
        chk("reset1", obs(1), {RST_M, RST_CC});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // subq: 3 - 5, then cmovl on the resulting flags
        set_e(1'b1, 3'd1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'd2, 4'hF);
        cycle();
        chk("t1_valE", {84'd0, m_valE[0]}, {84'd0, 64'hFFFF_FFFF_FFFF_FFFE});
        chk("t1_cc", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b010});
        set_e(1'b1, 3'd1, 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'd3, 4'hF);
        cycle();
        chk("t1_cmovl", {143'd0, m_cnd[0], m_dstE[0]}, {143'd0, 1'b1, 4'd3});

        // addq overflow, then jl / jg
        set_e(1'b1, 3'd1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd1, 4'hF);
        cycle();
        chk("t2_valE", {84'd0, m_valE[0]}, {84'd0, 64'h8000_0000_0000_0000});
        chk("t2_cc", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b011});
        set_e(1'b1, 3'd1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        cycle();
        chk("t2_jl", {147'd0, m_cnd[0]}, {147'd0, 1'b0});
        set_e(1'b1, 3'd1, 4'h7, 4'h6, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF);
        cycle();
        chk("t2_jg", {147'd0, m_cnd[0]}, {147'd0, 1'b1});

        // xorq with CC write blocked, then cmove sees the old ZF
        set_e(1'b1, 3'd1, 4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 4'd6, 4'hF);
        set_cc_en = 1'b0;
        cycle();
        chk("t3_valE", {84'd0, m_valE[0]}, 148'd0);
        chk("t3_cc", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b011});
        set_e(1'b1, 3'd1, 4'h2, 4'h3, 64'h99, 64'd0, 64'd0, 4'd5, 4'hF);
        cycle();
        chk("t3_cmove", {143'd0, m_cnd[0], m_dstE[0]}, {143'd0, 1'b0, 4'hF});

        // stall beats bubble; bubble alone loads a nop but lets CC update
        set_e(1'b1, 3'd1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'd4, 4'hF);
        cycle();
        set_e(1'b1, 3'd1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'd2, 4'hF);
        m_stall = 1'b1;
        m_bubble = 1'b1;
        cycle();
        chk("t4_hold", {84'd0, m_valE[0]}, {84'd0, 64'h1234});
        chk("t4_cchold", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b011});
        set_e(1'b1, 3'd1, 4'h6, 4'h3, 64'd9, 64'd9, 64'd0, 4'd2, 4'hF);
        m_bubble = 1'b1;
        cycle();
        chk("t4_bubble", {139'd0, m_icode[0], m_valid[0], m_dstE[0]}, {139'd0, 4'h1, 1'b0, 4'hF});
        chk("t4_ccupd", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b100});

        // shl: legal only with EXT_OPS=1
        set_e(1'b1, 3'd1, 4'h6, 4'h4, 64'd4, 64'd1, 64'd0, 4'd7, 4'hF);
        cycle();
        chk("t5_shl", {84'd0, m_valE[1]}, {84'd0, 64'd16});
        chk("t5_ins", {81'd0, m_stat[0], m_valE[0]}, {81'd0, 3'd4, 64'd0});
        chk("t5_cc0", {145'd0, cc_zf[0], cc_sf[0], cc_of[0]}, {145'd0, 3'b100});

        // pushq, then asynchronous reset mid-cycle
        set_e(1'b1, 3'd1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 4'hF);
        cycle();
        chk("t6_push", {84'd0, m_valE[0]}, {84'd0, 64'hF8});
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst0", obs(0), {RST_M, RST_CC});
        chk("t6_rst1", obs(1), {RST_M, RST_CC});
        for (int d = 0; d < 2; d++) begin
            exp_m[d] = RST_M;
            cc_m[d]  = RST_CC;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            set_e(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 5) < 3) ? 3'd1 : 3'($urandom_range(1, 4)),
                  4'($urandom_range(0, 11)),
                  ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15)),
                  rnd64(), rnd64(), rnd64(),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            set_cc_en = ($urandom_range(0, 7) != 0);
            m_stall   = ($urandom_range(0, 7) == 0);
            m_bubble  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
